// File: rtl/xbus_master_pkg.sv
// Shared xbus definitions: FSM encoding, bus widths, slave address map and request helpers.
package xbus_master_pkg;

  localparam int XBUS_ADDR_W = 32;
  localparam int XBUS_DATA_W = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // Slave address map as seen by the chip-select decoder
  localparam logic [XBUS_ADDR_W-1:0] ROM_BASE    = 32'h0000_0000;
  localparam logic [XBUS_ADDR_W-1:0] ROM_SIZE    = 32'h0001_0000;
  localparam logic [XBUS_ADDR_W-1:0] RAM_BASE    = 32'h0001_0000;
  localparam logic [XBUS_ADDR_W-1:0] RAM_SIZE    = 32'h0001_0000;
  localparam logic [XBUS_ADDR_W-1:0] PERIPH_BASE = 32'h8000_0000;
  localparam logic [XBUS_ADDR_W-1:0] PERIPH_SIZE = 32'h0000_1000;

  typedef struct packed {
    logic [XBUS_ADDR_W-1:0]   addr;
    logic                     we;
    logic [XBUS_DATA_W-1:0]   wdata;
    logic [XBUS_DATA_W/8-1:0] wstrb;
  } xbus_req_t;

  function automatic logic in_region(input logic [XBUS_ADDR_W-1:0] addr,
                                     input logic [XBUS_ADDR_W-1:0] base,
                                     input logic [XBUS_ADDR_W-1:0] size);
    return (addr - base) < size;
  endfunction

  function automatic logic addr_mapped(input logic [XBUS_ADDR_W-1:0] addr);
    return in_region(addr, ROM_BASE, ROM_SIZE) ||
           in_region(addr, RAM_BASE, RAM_SIZE) ||
           in_region(addr, PERIPH_BASE, PERIPH_SIZE);
  endfunction

  // Reads are word accesses; writes may use a single byte lane or the upper halfword
  function automatic logic misaligned(input logic [XBUS_ADDR_W-1:0] addr,
                                      input logic                   we,
                                      input logic [3:0]             wstrb);
    logic bad;
    bad = 1'b0;
    if (addr[1:0] != 2'b00) begin
      if (!we) begin
        bad = 1'b1;
      end else begin
        case (addr[1:0])
          2'd1:    bad = (wstrb != 4'b0010);
          2'd2:    bad = !((wstrb == 4'b0100) || (wstrb == 4'b1100));
          default: bad = (wstrb != 4'b1000);
        endcase
      end
    end
    return bad;
  endfunction

endpackage

// File: rtl/xbus_master_if.sv
// xbus master bundle: CPU request/response channel plus the xbus initiator signals.
interface xbus_master_if;

  logic                                    req_valid;
  logic                                    req_ready;
  logic [xbus_master_pkg::XBUS_ADDR_W-1:0] req_addr;
  logic                                    req_we;
  logic [xbus_master_pkg::XBUS_DATA_W-1:0] req_wdata;
  logic [3:0]                              req_wstrb;

  logic                                    resp_valid;
  logic [xbus_master_pkg::XBUS_DATA_W-1:0] resp_rdata;
  logic                                    resp_err;

  logic                                    xbus_as;
  logic [xbus_master_pkg::XBUS_ADDR_W-1:0] xbus_addr;
  logic                                    xbus_we;
  logic [xbus_master_pkg::XBUS_DATA_W-1:0] xbus_wdata;
  logic [3:0]                              xbus_wstrb;
  logic                                    xbus_hit;
  logic                                    xbus_ready;
  logic [xbus_master_pkg::XBUS_DATA_W-1:0] xbus_rdata;

  modport master (
    input  req_valid, req_addr, req_we, req_wdata, req_wstrb,
    input  xbus_hit, xbus_ready, xbus_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output xbus_as, xbus_addr, xbus_we, xbus_wdata, xbus_wstrb
  );

  modport slave (
    output req_valid, req_addr, req_we, req_wdata, req_wstrb,
    output xbus_hit, xbus_ready, xbus_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  xbus_as, xbus_addr, xbus_we, xbus_wdata, xbus_wstrb
  );

endinterface

// File: rtl/xbus_master.sv
// xbus initiator: one outstanding CPU access per transaction, with bounded wait and timeout.
// Optional XBUS_MASTER_ALIGN_CHK_EN rejects misaligned requests without touching the bus.
module xbus_master
  import xbus_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  xbus_master_if.master bus
);

  logic [1:0]             state;
  xbus_req_t              req_q;
  logic [CNT_W-1:0]       cnt;
  logic [XBUS_DATA_W-1:0] rdata_q;
  logic                   err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      req_q   <= '0;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            req_q <= '{addr:  bus.req_addr,
                       we:    bus.req_we,
                       wdata: bus.req_wdata,
                       wstrb: bus.req_wstrb};
`ifdef XBUS_MASTER_ALIGN_CHK_EN
            if (misaligned(bus.req_addr, bus.req_we, bus.req_wstrb)) begin
              err_q   <= 1'b1;
              rdata_q <= '0;
              state   <= ST_RESP;
            end else begin
              state <= ST_ADDR;
            end
`else
            state <= ST_ADDR;
`endif
          end
        end
        ST_ADDR: begin
          if (!bus.xbus_hit) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
            state   <= ST_RESP;
          end else begin
            cnt   <= '0;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A ready arriving on the final allowed cycle still completes cleanly
          if (bus.xbus_ready) begin
            rdata_q <= req_q.we ? '0 : bus.xbus_rdata;
            err_q   <= 1'b0;
            state   <= ST_RESP;
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state   <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == ST_IDLE);
  assign bus.resp_valid = (state == ST_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  // Read cycles present zero write data and no byte enables
  assign bus.xbus_as    = (state == ST_ADDR) || (state == ST_WAIT);
  assign bus.xbus_addr  = req_q.addr;
  assign bus.xbus_we    = req_q.we;
  assign bus.xbus_wdata = req_q.we ? req_q.wdata : '0;
  assign bus.xbus_wstrb = req_q.we ? req_q.wstrb : '0;

endmodule

// File: tb/tb_xbus_master.sv
// Self-checking bench for xbus_master: directed scenarios plus randomized traffic against a latency/result model.
module tb_xbus_master;
  import xbus_master_pkg::*;

  localparam int TO = 16;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  xbus_master_if bif ();

  xbus_master #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.master)
  );

  // Behavioural chip-select decoder
  assign bif.xbus_hit = addr_mapped(bif.xbus_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outcome of one access, straight from the protocol rules
  function automatic void model(input logic [31:0] addr, input logic we,
                                input logic [3:0] wstrb, input int d,
                                input logic [31:0] srd,
                                output int lat, output int as_cyc,
                                output logic [31:0] rd, output logic err);
    logic mis;
    int   o;
    o   = int'(addr[1:0]);
    mis = 1'b0;
`ifdef XBUS_MASTER_ALIGN_CHK_EN
    if (o != 0)
      mis = !we || !((wstrb == 4'(1 << o)) || (o == 2 && wstrb == 4'b1100));
`endif
    rd = 32'h0;
    if (mis) begin
      lat = 1; as_cyc = 0; err = 1'b1;
    end else if (!addr_mapped(addr)) begin
      lat = 2; as_cyc = 1; err = 1'b1;
    end else if (d >= 0 && d < TO) begin
      lat = 3 + d; as_cyc = 2 + d; err = 1'b0;
      rd = we ? 32'h0 : srd;
    end else begin
      lat = TO + 2; as_cyc = TO + 1; err = 1'b1;
    end
  endfunction

  // One transaction; starts and ends just after a falling edge
  task automatic run_txn(input string name, input logic [31:0] addr, input logic we,
                         input logic [31:0] wdata, input logic [3:0] wstrb,
                         input int d, input logic [31:0] srd, input bit late_ready);
    int          e_lat, e_as, c, lat, as_cnt, bad, n;
    logic [31:0] e_rd, rd;
    logic        e_err, er, rr, got, noise;
    model(addr, we, wstrb, d, srd, e_lat, e_as, e_rd, e_err);
    n = 0;
    while (!bif.req_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    bif.req_valid = 1'b1;
    bif.req_addr  = addr;
    bif.req_we    = we;
    bif.req_wdata = wdata;
    bif.req_wstrb = wstrb;
    @(negedge clk);
    bif.req_valid = 1'b0;
    bif.req_addr  = $urandom;
    bif.req_we    = 1'($urandom);
    bif.req_wdata = $urandom;
    bif.req_wstrb = 4'($urandom);
    noise  = 1'($urandom_range(0, 1));
    c      = 1;
    got    = 1'b0;
    as_cnt = 0;
    bad    = 0;
    lat    = 0;
    rd     = 32'h0;
    er     = 1'b0;
    rr     = 1'b0;
    while (!got && c <= 64) begin
      if (bif.xbus_as) begin
        as_cnt++;
        if (bif.xbus_addr !== addr || bif.xbus_we !== we ||
            bif.xbus_wdata !== (we ? wdata : 32'h0) || bif.xbus_wstrb !== (we ? wstrb : 4'h0))
          bad++;
      end
      if (bif.resp_valid) begin
        got = 1'b1;
        lat = c;
        rd  = bif.resp_rdata;
        er  = bif.resp_err;
        rr  = bif.req_ready;
      end else begin
        bif.xbus_ready = (c == 1) ? noise : (d >= 0 && c == 2 + d);
        bif.xbus_rdata = (c == 2 + d) ? srd : $urandom;
        @(negedge clk);
        c++;
      end
    end
    bif.xbus_ready = 1'b0;
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("[TB] FAIL %s no_resp: no resp_valid within %0d cycles, required at cycle %0d", name, c - 1, e_lat);
      return;
    end
    tests_run++;
    if (lat !== e_lat) begin
      tests_failed++;
      $display("[TB] FAIL %s latency: got %0d cycles, expected %0d", name, lat, e_lat);
    end
    tests_run++;
    if (rd !== e_rd || er !== e_err) begin
      tests_failed++;
      $display("[TB] FAIL %s resp: got rdata=%h err=%b, expected rdata=%h err=%b", name, rd, er, e_rd, e_err);
    end
    tests_run++;
    if (as_cnt !== e_as || bad !== 0 || rr !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL %s bus: as_cycles=%0d unstable=%0d req_ready_in_resp=%b, expected %0d/0/0", name, as_cnt, bad, rr, e_as);
    end
    bif.xbus_ready = late_ready;
    @(negedge clk);
    bif.xbus_ready = 1'b0;
    tests_run++;
    if (bif.resp_valid !== 1'b0 || bif.req_ready !== 1'b1 || bif.xbus_as !== 1'b0 ||
        bif.resp_rdata !== e_rd || bif.resp_err !== e_err) begin
      tests_failed++;
      $display("[TB] FAIL %s after_resp: valid=%b ready=%b as=%b rdata=%h err=%b, expected 0/1/0/%h/%b",
               name, bif.resp_valid, bif.req_ready, bif.xbus_as, bif.resp_rdata, bif.resp_err, e_rd, e_err);
    end
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bif.req_valid  = 1'b0;
    bif.req_addr   = 32'h0;
    bif.req_we     = 1'b0;
    bif.req_wdata  = 32'h0;
    bif.req_wstrb  = 4'h0;
    bif.xbus_ready = 1'b0;
    bif.xbus_rdata = 32'h0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bif.req_ready !== 1'b1 || bif.resp_valid !== 1'b0 || bif.xbus_as !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl: ready=%b valid=%b as=%b, expected 1/0/0", bif.req_ready, bif.resp_valid, bif.xbus_as);
    end
    tests_run++;
    if (bif.resp_rdata !== 32'h0 || bif.resp_err !== 1'b0 || bif.xbus_addr !== 32'h0 ||
        bif.xbus_we !== 1'b0 || bif.xbus_wdata !== 32'h0 || bif.xbus_wstrb !== 4'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data: rdata=%h err=%b addr=%h we=%b wdata=%h wstrb=%h, expected all 0",
               bif.resp_rdata, bif.resp_err, bif.xbus_addr, bif.xbus_we, bif.xbus_wdata, bif.xbus_wstrb);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bif.req_ready !== 1'b1 || bif.xbus_as !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_release: ready=%b as=%b, expected 1/0", bif.req_ready, bif.xbus_as);
    end
  endtask

  task automatic test_read_basic();
    run_txn("read_basic", 32'h8000_0010, 1'b0, 32'h0, 4'hF, 0, 32'hDEAD_BEEF, 1'b0);
  endtask

  task automatic test_write_wait();
    run_txn("write_wait", 32'h0000_1004, 1'b1, 32'h1234_5678, 4'hF, 3, 32'hCAFE_F00D, 1'b0);
  endtask

  task automatic test_unmapped();
    run_txn("unmapped", 32'h0002_0000, 1'b0, 32'h0, 4'hF, 0, 32'h5555_AAAA, 1'b0);
  endtask

  task automatic test_timeout();
    run_txn("timeout", 32'h0001_0000, 1'b0, 32'h0, 4'hF, -1, 32'h0, 1'b1);
  endtask

  task automatic test_ready_at_timeout();
    run_txn("ready_at_limit", 32'h0001_0040, 1'b0, 32'h0, 4'hF, TO - 1, 32'hA5A5_0F0F, 1'b0);
  endtask

  task automatic test_reset_mid();
    int n;
    bif.req_valid = 1'b1;
    bif.req_addr  = 32'h0001_0000;
    bif.req_we    = 1'b0;
    bif.req_wstrb = 4'hF;
    @(negedge clk);
    bif.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bif.xbus_as !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_pre: as=%b, expected 1", bif.xbus_as);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (bif.xbus_as !== 1'b0 || bif.resp_valid !== 1'b0 || bif.req_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_async: as=%b valid=%b ready=%b, expected 0/0/1", bif.xbus_as, bif.resp_valid, bif.req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bif.resp_valid === 1'b1) n++;
    end
    tests_run++;
    if (n !== 0 || bif.req_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_quiet: resp pulses=%0d ready=%b, expected 0/1", n, bif.req_ready);
    end
    run_txn("after_reset", 32'h0000_2000, 1'b0, 32'h0, 4'hF, 1, 32'h0BAD_C0DE, 1'b0);
  endtask

  task automatic test_align();
    run_txn("align_read", 32'h8000_0002, 1'b0, 32'h0, 4'hF, 0, 32'h1111_2222, 1'b0);
    run_txn("align_half", 32'h8000_0002, 1'b1, 32'hBEEF_0000, 4'b1100, 0, 32'h0, 1'b0);
    run_txn("align_badw", 32'h8000_0001, 1'b1, 32'h0000_3300, 4'b0011, 1, 32'h0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0:       a = ROM_BASE + ($urandom & 32'h0000_FFFC);
        1:       a = RAM_BASE + ($urandom & 32'h0000_FFFC);
        2:       a = PERIPH_BASE + ($urandom & 32'h0000_0FFC);
        default: a = 32'h0002_0000 + ($urandom & 32'h000F_FFFC);
      endcase
      run_txn("random", a, 1'($urandom), $urandom, 4'($urandom_range(1, 15)),
              int'($urandom_range(0, TO + 3)) - 1, $urandom, 1'($urandom));
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_read_basic();
    test_write_wait();
    test_unmapped();
    test_timeout();
    test_ready_at_timeout();
    test_reset_mid();
    test_align();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/xbus_master.md
Name: xbus_master

Overview:
- Initiator end of the xbus: turns one CPU-side load/store request into one xbus transaction and returns read data or an error.
- Drives xbus_as/xbus_addr into the existing chip-select decoder and the slaves.
- Collects the slave's ready/rdata and reports the result on a response channel.
- Single outstanding transaction; bounded wait with timeout so an unmapped or stuck access cannot hang the core.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles in WAIT before the access is aborted with an error; legal range 1..255.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  CPU request valid
- req_ready  out  1  request accepted when valid&ready
- req_addr  in  32  byte address
- req_we  in  1  1=write, 0=read
- req_wdata  in  32  write data
- req_wstrb  in  4  byte enables
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  read data; 0 on writes and errors
- resp_err  out  1  access faulted; qualified by resp_valid
- xbus_as  out  1  address strobe
- xbus_addr  out  32  bus address
- xbus_we  out  1  bus write
- xbus_wdata  out  32  bus write data
- xbus_wstrb  out  4  bus byte enables
- xbus_hit  in  1  OR of all decoder chip-selects
- xbus_ready  in  1  selected slave completes the access
- xbus_rdata  in  32  slave read data, valid with xbus_ready

Behaviour:
- Reset (async assert, sync deassert handled upstream): state IDLE.
  - All outputs 0, except req_ready=1.
  - Counter 0; captured address/data/strobe registers 0.
- States: IDLE, ADDR, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, capture addr/we/wdata/wstrb and go to ADDR.
- ADDR (1 cycle):
  - xbus_as=1; bus outputs driven from the captured registers.
  - Sample xbus_hit; if 0, go to RESP with err=1 (no wait). Otherwise go to WAIT with counter=0.
- WAIT:
  - xbus_as stays 1; bus outputs stay stable.
  - If xbus_ready=1: latch xbus_rdata (reads only; writes latch 0), err=0, go to RESP.
  - Else if counter==TIMEOUT_CYCLES-1: err=1, rdata=0, go to RESP.
  - Else increment counter.
- RESP (1 cycle):
  - xbus_as=0; resp_valid=1 with the registered rdata/err; next state IDLE.
  - resp_rdata/resp_err hold their values until the next RESP.
- Latency:
  - Minimum request-accept to resp_valid is 3 cycles (ADDR, WAIT with immediate ready, RESP).
  - Unmapped access: 2 cycles.
  - Timeout: TIMEOUT_CYCLES+2 cycles.
- req_ready is 0 in ADDR/WAIT/RESP; back-to-back requests therefore take a minimum of 4 cycles each.
- A request presented during RESP is not accepted until IDLE.
- xbus_ready outside WAIT is ignored, including a late ready after timeout.
- xbus_ready and timeout in the same cycle: ready wins, no error.
- xbus_wstrb is forced to 0 on reads; xbus_wdata is don't-care on reads but driven to 0.
- Reset mid-transaction drops xbus_as immediately and produces no response.

Optional Feature:
- Macro: XBUS_MASTER_ALIGN_CHK_EN.
- Defined: in IDLE, an accepted request is misaligned if addr[1:0]!=0 and wstrb is not a legal byte/halfword lane pattern for that offset.
  - Reads are checked as word reads: any addr[1:0]!=0 is misaligned.
  - A misaligned request skips ADDR/WAIT, goes directly to RESP with err=1, and never asserts xbus_as.
- Undefined: no alignment check; the address is passed through unchanged.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE=0, ADDR=1, WAIT=2, RESP=3);
  - XBUS_ADDR_W=32, XBUS_DATA_W=32;
  - the slave address map constants already used by the decoder, so the bench and RTL agree on mapped/unmapped addresses.
- No sub-module required. The wait/timeout counter may optionally be a small xbus_wait_timer (enable, clear, expired output).

Test Plan:
- Read 0x80000010, slave ready on first WAIT cycle with rdata 0xDEADBEEF -> resp_valid at cycle 3 after accept, rdata=0xDEADBEEF, err=0; xbus_as high exactly 2 cycles.
- Write 0x00001004 wdata 0x12345678 wstrb 0xF, ready after 3 wait cycles -> xbus_we=1 with addr/data/strobe stable throughout WAIT; resp err=0, rdata=0.
- Read 0x00020000 (xbus_hit=0) -> resp_valid 2 cycles after accept, err=1, no WAIT.
- Mapped read 0x00010000, ready never asserted, TIMEOUT_CYCLES=16 -> resp at cycle 18, err=1; a late ready one cycle later is ignored.
- rst_n pulsed low during WAIT -> xbus_as drops asynchronously, no resp_valid, req_ready=1 after release; the next request completes normally.
- With XBUS_MASTER_ALIGN_CHK_EN: read 0x80000002 -> err=1 in 1 cycle, xbus_as never asserted. Without the macro, the same access reaches the bus.
